// File: rtl/ifmap_feeder.sv
// ifmap_feeder: write-side controller for the per-lane ifmap FIFO buffer.
// Streams a contiguous GLB tile one word per cycle and deals the words
// round-robin to the active lanes. Per-lane credit counters track how much
// free space each lane has, so no lane is overrun.
// Optional: define IFMAP_FEEDER_ERR_EN to add a sticky `err` output.
module ifmap_feeder #(
    parameter int NUM_LANES  = 32,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [CNT_W-1:0]              words_per_lane,
    input  logic [5:0]                    lane_cnt,
    output logic                          busy,
    output logic                          done,
    output logic                          glb_re,
    output logic [ADDR_W-1:0]             glb_addr,
    input  logic [DATA_W-1:0]             glb_rdata,
    output logic [NUM_LANES-1:0]          push,
    output logic [NUM_LANES*DATA_W-1:0]   push_data,
    input  logic [NUM_LANES-1:0]          pop_ack
`ifdef IFMAP_FEEDER_ERR_EN
    ,
    output logic                          err
`endif
);

    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    wpl_q;
    logic [CNT_W-1:0]    round_q;
    logic [5:0]          lanes_q;
    logic [5:0]          lane_q;
    logic                push_v_q;
    logic [5:0]          push_lane_q;
    logic [CRED_W-1:0]   credit [NUM_LANES];

    logic [5:0]          lanes_clamped;
    logic                lane_has_credit;
    logic                issue;
    logic                last_issue;
    logic [NUM_LANES-1:0] issue_vec;
    logic [NUM_LANES-1:0] at_depth;

    assign lanes_clamped = (lane_cnt > 6'(NUM_LANES)) ? 6'(NUM_LANES) : lane_cnt;

    // Issue decision: the current target lane must have credit; no skipping.
    always_comb begin
        lane_has_credit = 1'b0;
        issue_vec       = '0;
        at_depth        = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            at_depth[i] = (credit[i] == CRED_W'(FIFO_DEPTH));
            if (lane_q == 6'(i)) begin
                lane_has_credit = (credit[i] != '0);
            end
        end
        issue = (state == S_RUN) && lane_has_credit;
        for (int i = 0; i < NUM_LANES; i++) begin
            issue_vec[i] = issue && (lane_q == 6'(i));
        end
        last_issue = issue && (lane_q == lanes_q - 6'd1) &&
                     (round_q == wpl_q - CNT_W'(1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; empty jobs go straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (words_per_lane == '0 || lanes_clamped == '0) state_nxt = S_DONE;
                    else                                             state_nxt = S_RUN;
                end
            end
            S_RUN:   if (last_issue) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy     = (state == S_RUN) || (state == S_DRAIN);
    assign done     = (state == S_DONE);
    assign glb_re   = issue;
    assign glb_addr = issue ? addr_q : '0;

    // Job registers, address/lane/round counters and the one-cycle push pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            wpl_q       <= '0;
            lanes_q     <= '0;
            lane_q      <= '0;
            round_q     <= '0;
            push_v_q    <= 1'b0;
            push_lane_q <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                addr_q  <= base_addr;
                wpl_q   <= words_per_lane;
                lanes_q <= lanes_clamped;
                lane_q  <= '0;
                round_q <= '0;
            end else if (issue) begin
                addr_q <= addr_q + ADDR_W'(1);
                if (lane_q == lanes_q - 6'd1) begin
                    lane_q  <= '0;
                    round_q <= round_q + CNT_W'(1);
                end else begin
                    lane_q <= lane_q + 6'd1;
                end
            end
            push_v_q    <= issue;
            push_lane_q <= lane_q;
        end
    end

    // Read data returns one cycle after issue and goes to the lane it was issued for.
    always_comb begin
        push      = '0;
        push_data = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (push_v_q && push_lane_q == 6'(i)) begin
                push[i]                      = 1'b1;
                push_data[i*DATA_W +: DATA_W] = glb_rdata;
            end
        end
    end

    // Credit counters: issue consumes, accepted pop returns, saturating at depth.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (rst) begin
                credit[i] <= CRED_W'(FIFO_DEPTH);
            end else if (issue_vec[i] && !pop_ack[i]) begin
                credit[i] <= credit[i] - CRED_W'(1);
            end else if (!issue_vec[i] && pop_ack[i] && !at_depth[i]) begin
                credit[i] <= credit[i] + CRED_W'(1);
            end
        end
    end

`ifdef IFMAP_FEEDER_ERR_EN
    // Sticky protocol error: pop to a full-credit lane, or start while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((|(pop_ack & at_depth)) || (start && state != S_IDLE)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule
